gpu_attr_interp: RTL and testbench

- Pipelined, parametrised per-pixel attribute interpolator for the rasteriser.
- Per primitive: latches base/horizontal/vertical gradients for R, G, B, U, V.
- Per accepted request: emits LANES adjacent pixels' attributes through a valid/ready handshake.
- Sits between the span walker and the texture/blend stage. Supports absolute seeks (multiply) and incremental span steps (add only), with stall support and optional colour saturation.

---
 rtl/gpu_attr_pkg.sv | 13 +
 rtl/gpu_attr_lane.sv | 27 ++
 rtl/gpu_attr_interp.sv | 121 ++++++++++++
 tb/tb_gpu_attr_interp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_attr_pkg.sv
// gpu_attr_pkg: shared widths, channel indices and colour clamp for gpu_attr_interp.
package gpu_attr_pkg;
    typedef enum logic [2:0] {CH_R, CH_G, CH_B, CH_U, CH_V} chan_e;
    function automatic int wcol(input int subw);
        return subw + 20;
    endfunction
    function automatic int wtex(input int subw);
        return subw + 19;
    endfunction
    function automatic logic [8:0] clamp_col(input logic signed [19:0] ip);
        return (ip < 20'sd0) ? 9'd0 : (ip > 20'sd255) ? 9'd255 : ip[8:0];
    endfunction
endpackage

// File: rtl/gpu_attr_lane.sv
// gpu_attr_lane: one pixel of a beat; extracts R/G/B/U/V and forwards acc+hori to the next lane.
// GPU_ATTR_CLAMP_EN saturates colour to 0..255 on the full integer part.
module gpu_attr_lane
    import gpu_attr_pkg::*;
#(
    parameter int SUBW = 16,
    localparam int WCol = wcol(SUBW)
) (
    input  logic [4:0][WCol-1:0] i_acc,
    input  logic [4:0][WCol-1:0] i_hori,
    output logic [4:0][WCol-1:0] o_acc,
    output logic [2:0][8:0]      o_col,
    output logic [1:0][7:0]      o_tex
);
    for (genvar g = 0; g < 5; g++) begin : g_next
        assign o_acc[g] = i_acc[g] + i_hori[g];
    end
    for (genvar g = 0; g < 3; g++) begin : g_col
`ifdef GPU_ATTR_CLAMP_EN
        assign o_col[g] = clamp_col(i_acc[g][WCol-1:SUBW]);
`else
        assign o_col[g] = i_acc[g][SUBW+8:SUBW];
`endif
    end
    assign o_tex[0] = i_acc[CH_U][SUBW+7:SUBW];
    assign o_tex[1] = i_acc[CH_V][SUBW+7:SUBW];
endmodule

// File: rtl/gpu_attr_interp.sv
// gpu_attr_interp: two-stage R/G/B/U/V interpolator emitting LANES adjacent pixels per beat.
// Define GPU_ATTR_CLAMP_EN to saturate colour lanes to 0..255.
module gpu_attr_interp
    import gpu_attr_pkg::*;
#(
    parameter int SUBW  = 16,
    parameter int LANES = 2
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    i_load,
    input  logic signed [SUBW+8:0]  i_baseR,
    input  logic signed [SUBW+8:0]  i_baseG,
    input  logic signed [SUBW+8:0]  i_baseB,
    input  logic signed [SUBW+7:0]  i_baseU,
    input  logic signed [SUBW+7:0]  i_baseV,
    input  logic signed [SUBW+8:0]  i_horiR,
    input  logic signed [SUBW+8:0]  i_horiG,
    input  logic signed [SUBW+8:0]  i_horiB,
    input  logic signed [SUBW+7:0]  i_horiU,
    input  logic signed [SUBW+7:0]  i_horiV,
    input  logic signed [SUBW+8:0]  i_vertR,
    input  logic signed [SUBW+8:0]  i_vertG,
    input  logic signed [SUBW+8:0]  i_vertB,
    input  logic signed [SUBW+7:0]  i_vertU,
    input  logic signed [SUBW+7:0]  i_vertV,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_step,
    input  logic [9:0]              i_x,
    input  logic [8:0]              i_y,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [9*LANES-1:0]      o_R,
    output logic [9*LANES-1:0]      o_G,
    output logic [9*LANES-1:0]      o_B,
    output logic [8*LANES-1:0]      o_U,
    output logic [8*LANES-1:0]      o_V
);
    localparam int WCol = wcol(SUBW);
    localparam int LG   = $clog2(LANES);
    typedef logic [4:0][WCol-1:0] vec_t;

    vec_t w_base, w_hori, w_vert, w_acc0;
    vec_t r_base, r_hori, r_vert, r_last, r_s1_acc;
    vec_t w_chain [LANES+1];
    logic [LANES-1:0][2:0][8:0] w_col, r_col;
    logic [LANES-1:0][1:0][7:0] w_tex, r_tex;
    logic [WCol-1:0] w_xe, w_ye;
    logic r_s1_v, r_s2_v, r_fresh, w_s2_adv, w_accept;

    assign w_base = {WCol'(i_baseV), WCol'(i_baseU), WCol'(i_baseB), WCol'(i_baseG), WCol'(i_baseR)};
    assign w_hori = {WCol'(i_horiV), WCol'(i_horiU), WCol'(i_horiB), WCol'(i_horiG), WCol'(i_horiR)};
    assign w_vert = {WCol'(i_vertV), WCol'(i_vertU), WCol'(i_vertB), WCol'(i_vertG), WCol'(i_vertR)};
    assign w_xe = WCol'(i_x);
    assign w_ye = WCol'(i_y);

    assign w_s2_adv = !r_s2_v || i_ready;
    assign o_ready  = !r_s1_v || w_s2_adv;
    assign w_accept = i_valid && o_ready && !i_load;
    assign o_valid  = r_s2_v;

    // The first step after load/reset lands on (0,0) itself rather than LANES pixels past it.
    for (genvar c = 0; c < 5; c++) begin : g_s1
        assign w_acc0[c] = i_step ? r_last[c] + (r_fresh ? '0 : (r_hori[c] << LG))
                                  : r_base[c] + w_xe * r_hori[c] + w_ye * r_vert[c];
    end

    assign w_chain[0] = r_s1_acc;
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gpu_attr_lane #(.SUBW(SUBW)) u_lane (
            .i_acc  (w_chain[k]),
            .i_hori (r_hori),
            .o_acc  (w_chain[k+1]),
            .o_col  (w_col[k]),
            .o_tex  (w_tex[k])
        );
        assign o_R[9*k +: 9] = r_col[k][0];
        assign o_G[9*k +: 9] = r_col[k][1];
        assign o_B[9*k +: 9] = r_col[k][2];
        assign o_U[8*k +: 8] = r_tex[k][0];
        assign o_V[8*k +: 8] = r_tex[k][1];
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_base   <= '0;
            r_hori   <= '0;
            r_vert   <= '0;
            r_last   <= '0;
            r_s1_acc <= '0;
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_fresh  <= 1'b1;
            r_col    <= '0;
            r_tex    <= '0;
        end else if (i_load) begin
            r_base  <= w_base;
            r_hori  <= w_hori;
            r_vert  <= w_vert;
            r_last  <= w_base;
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            r_fresh <= 1'b1;
        end else begin
            if (w_accept) begin
                r_s1_acc <= w_acc0;
                r_last   <= w_acc0;
                r_fresh  <= 1'b0;
            end
            r_s1_v <= w_accept || (r_s1_v && !w_s2_adv);
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_col <= w_col;
                    r_tex <= w_tex;
                end
            end
        end
    end
endmodule

// File: tb/tb_gpu_attr_interp.sv
// tb_gpu_attr_interp: directed and random checks of gpu_attr_interp against a pixel-position model.
module tb_gpu_attr_interp;
    localparam int SUBW = 16;
    localparam int L    = 2;
    localparam int WCOL = SUBW + 20;

    logic clk = 1'b0, nRst = 1'b0, i_load = 1'b0, i_valid = 1'b0, i_step = 1'b0, i_ready = 1'b0;
    logic signed [SUBW+8:0] i_baseR = '0, i_baseG = '0, i_baseB = '0;
    logic signed [SUBW+8:0] i_horiR = '0, i_horiG = '0, i_horiB = '0;
    logic signed [SUBW+8:0] i_vertR = '0, i_vertG = '0, i_vertB = '0;
    logic signed [SUBW+7:0] i_baseU = '0, i_baseV = '0, i_horiU = '0, i_horiV = '0, i_vertU = '0, i_vertV = '0;
    logic [9:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic o_ready, o_valid;
    logic [9*L-1:0] o_R, o_G, o_B;
    logic [8*L-1:0] o_U, o_V;

    gpu_attr_interp #(.SUBW(SUBW), .LANES(L)) dut (
        .clk(clk), .nRst(nRst), .i_load(i_load),
        .i_baseR(i_baseR), .i_baseG(i_baseG), .i_baseB(i_baseB), .i_baseU(i_baseU), .i_baseV(i_baseV),
        .i_horiR(i_horiR), .i_horiG(i_horiG), .i_horiB(i_horiB), .i_horiU(i_horiU), .i_horiV(i_horiV),
        .i_vertR(i_vertR), .i_vertG(i_vertG), .i_vertB(i_vertB), .i_vertU(i_vertU), .i_vertV(i_vertV),
        .i_valid(i_valid), .o_ready(o_ready), .i_step(i_step), .i_x(i_x), .i_y(i_y),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_U(o_U), .o_V(o_V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*L-1:0] r, g, b;
        logic [8*L-1:0] u, v;
    } beat_t;

    beat_t q[$];
    longint nb[5], nh[5], nv[5];
    longint gb[5], gh[5], gv[5];
    int px = 0, py = 0, n_del = 0, n_chk = 0, n_err = 0;
    bit fresh = 1'b1, acc_f = 1'b0;
    logic [9*L-1:0] last_R = '0, s_R = '0;
    logic s_vld = 1'b0, s_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint wrapc(input longint v);
        return (v <<< (64 - WCOL)) >>> (64 - WCOL);
    endfunction

    function automatic longint rnd(input int w);
        longint v;
        v = longint'($urandom);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Pixel (px+k, py) value straight from base + x*hori + y*vert.
    function automatic void push_exp();
        beat_t e;
        for (int k = 0; k < L; k++) begin
            for (int c = 0; c < 5; c++) begin
                longint v, ip;
                logic [8:0] col;
                v  = wrapc(gb[c] + longint'(px + k) * gh[c] + longint'(py) * gv[c]);
                ip = v >>> SUBW;
                col = ip[8:0];
`ifdef GPU_ATTR_CLAMP_EN
                if (c < 3) col = (ip < 0) ? 9'd0 : (ip > 255) ? 9'd255 : ip[8:0];
`endif
                case (c)
                    0: e.r[9*k +: 9] = col;
                    1: e.g[9*k +: 9] = col;
                    2: e.b[9*k +: 9] = col;
                    3: e.u[8*k +: 8] = col[7:0];
                    default: e.v[8*k +: 8] = col[7:0];
                endcase
            end
        end
        q.push_back(e);
    endfunction

    task automatic tick();
        beat_t e;
        #1;
        acc_f = 1'b0;
        s_R = o_R;
        s_vld = o_valid;
        s_rdy = o_ready;
        if (!i_load && o_valid && i_ready) begin
            if (q.size() == 0) check("spurious_beat", o_valid, 0);
            else begin
                e = q.pop_front();
                check("beat_R", o_R, e.r);
                check("beat_G", o_G, e.g);
                check("beat_B", o_B, e.b);
                check("beat_U", o_U, e.u);
                check("beat_V", o_V, e.v);
                last_R = o_R;
                n_del++;
            end
        end
        if (i_load) begin
            q.delete();
            gb = nb; gh = nh; gv = nv;
            px = 0; py = 0; fresh = 1'b1;
        end else if (i_valid && o_ready) begin
            acc_f = 1'b1;
            if (!i_step) begin px = int'(i_x); py = int'(i_y); end
            else if (!fresh) px += L;
            fresh = 1'b0;
            push_exp();
        end
        @(negedge clk);
    endtask

    task automatic clr_g();
        for (int c = 0; c < 5; c++) begin nb[c] = 0; nh[c] = 0; nv[c] = 0; end
    endtask

    task automatic do_load();
        i_baseR = nb[0][SUBW+8:0]; i_baseG = nb[1][SUBW+8:0]; i_baseB = nb[2][SUBW+8:0];
        i_baseU = nb[3][SUBW+7:0]; i_baseV = nb[4][SUBW+7:0];
        i_horiR = nh[0][SUBW+8:0]; i_horiG = nh[1][SUBW+8:0]; i_horiB = nh[2][SUBW+8:0];
        i_horiU = nh[3][SUBW+7:0]; i_horiV = nh[4][SUBW+7:0];
        i_vertR = nv[0][SUBW+8:0]; i_vertG = nv[1][SUBW+8:0]; i_vertB = nv[2][SUBW+8:0];
        i_vertU = nv[3][SUBW+7:0]; i_vertV = nv[4][SUBW+7:0];
        i_load = 1'b1;
        i_ready = 1'b0;
        tick();
        i_load = 1'b0;
    endtask

    task automatic req(input bit st, input int x, input int y);
        int d0;
        d0 = n_del;
        i_valid = 1'b1; i_step = st; i_x = 10'(x); i_y = 9'(y); i_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (acc_f) break;
        end
        check("req_accept", acc_f, 1);
        i_valid = 1'b0;
        for (int t = 0; t < 10 && n_del == d0; t++) tick();
        check("req_deliver", n_del - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9*L-1:0] hold;
        int sent, d0;
        clr_g();
        gb = nb; gh = nh; gv = nv;
        @(negedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_R", o_R, 0);
        check("rst_U", o_U, 0);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        clr_g();
        nb[0] = 10 <<< 16; nh[0] = 1 <<< 16; nv[0] = 2 <<< 16;
        do_load();
        req(1, 0, 0);
        check("step_after_load", last_R, {9'd11, 9'd10});
        req(0, 3, 4);
        check("seek", last_R, {9'd22, 9'd21});
        req(1, 0, 0);
        check("step", last_R, {9'd24, 9'd23});

        clr_g();
        nb[0] = 250 <<< 16; nh[0] = 4 <<< 16;
        do_load();
        req(0, 2, 0);
`ifdef GPU_ATTR_CLAMP_EN
        check("clamp_hi", last_R, {9'd255, 9'd255});
`else
        check("wrap_hi", last_R, {9'h106, 9'h102});
`endif
        clr_g();
        nb[0] = -(64'sd1 <<< 16);
        do_load();
        req(0, 0, 0);
`ifdef GPU_ATTR_CLAMP_EN
        check("clamp_lo", last_R, {9'd0, 9'd0});
`else
        check("wrap_lo", last_R, {9'h1FF, 9'h1FF});
`endif

        for (int c = 0; c < 5; c++) begin
            nb[c] = rnd(SUBW + 8); nh[c] = rnd(SUBW + 4); nv[c] = rnd(SUBW + 4);
        end
        do_load();
        sent = 0;
        d0 = n_del;
        hold = '0;
        for (int cyc = 0; cyc < 30 && n_del - d0 < 4; cyc++) begin
            i_ready = (cyc >= 5);
            i_valid = (sent < 4);
            i_step = 1'b0;
            i_x = 10'(sent * 37 + 5);
            i_y = 9'(sent * 11 + 1);
            tick();
            if (acc_f) sent++;
            if (cyc == 2) hold = s_R;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_ready_low", s_rdy, 0);
                check("bp_valid", s_vld, 1);
            end
            if (cyc == 3 || cyc == 4) check("bp_hold", s_R, hold);
            if (cyc == 4) check("bp_accepts", sent, 2);
        end
        i_valid = 1'b0;
        check("bp_delivered", n_del - d0, 4);

        i_ready = 1'b0;
        i_valid = 1'b1;
        i_step = 1'b0;
        for (int t = 0; t < 2; t++) begin
            i_x = 10'(t + 1);
            tick();
        end
        i_valid = 1'b0;
        clr_g();
        nb[0] = 100 <<< 16;
        d0 = n_del;
        do_load();
        #1;
        check("flush_valid", o_valid, 0);
        check("flush_ready", o_ready, 1);
        @(negedge clk);
        req(0, 5, 5);
        check("flush_new_grad", last_R, {9'd100, 9'd100});
        check("flush_one_beat", n_del - d0, 1);

        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 0) begin
                for (int c = 0; c < 5; c++) begin
                    nb[c] = rnd((c < 3) ? SUBW + 9 : SUBW + 8);
                    nh[c] = rnd((c < 3) ? SUBW + 9 : SUBW + 8);
                    nv[c] = rnd((c < 3) ? SUBW + 9 : SUBW + 8);
                end
                do_load();
            end
            i_valid = ($urandom_range(0, 3) != 0);
            i_step = $urandom_range(0, 1);
            i_x = 10'($urandom);
            i_y = 9'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int t = 0; t < 10 && q.size() != 0; t++) tick();
        check("drain_empty", q.size(), 0);

        i_valid = 1'b1;
        i_step = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        nRst = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_R", o_R, 0);
        check("mid_rst_V", o_V, 0);
        q.delete();
        clr_g();
        gb = nb; gh = nh; gv = nv;
        px = 0; py = 0; fresh = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        tick();
        check("post_rst_ready", s_rdy, 1);
        req(1, 0, 0);
        check("post_rst_step", last_R, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
